// File: rtl/registerfile_param.sv
// Parametrised CPU register file: 2**SEL_WIDTH registers, paired into address registers with inc/dec.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module registerfile_param #(
  parameter  int DATA_WIDTH     = 8,
  parameter  int SEL_WIDTH      = 3,
  localparam int PAIR_SEL_WIDTH = SEL_WIDTH - 1
) (
  input  logic                      CLK,
  input  logic                      RST_bar,
  input  logic                      MAIN_LOAD_bar,
  input  logic [SEL_WIDTH-1:0]      MAIN_LOAD_SEL,
  input  logic [DATA_WIDTH-1:0]     MAIN_in,
  input  logic                      MAIN_ASSERT_bar,
  input  logic [SEL_WIDTH-1:0]      MAIN_ASSERT_SEL,
  output logic [DATA_WIDTH-1:0]     MAIN_out,
  input  logic                      LHS_ASSERT_bar,
  input  logic [SEL_WIDTH-1:0]      LHS_ASSERT_SEL,
  output logic [DATA_WIDTH-1:0]     LHS_out,
  input  logic                      RHS_ASSERT_bar,
  input  logic [SEL_WIDTH-1:0]      RHS_ASSERT_SEL,
  output logic [DATA_WIDTH-1:0]     RHS_out,
  input  logic                      ADDR_LOAD_bar,
  input  logic [PAIR_SEL_WIDTH-1:0] ADDR_LOAD_SEL,
  input  logic [2*DATA_WIDTH-1:0]   ADDR_in,
  input  logic                      ADDR_ASSERT_bar,
  input  logic [PAIR_SEL_WIDTH-1:0] ADDR_ASSERT_SEL,
  output logic [2*DATA_WIDTH-1:0]   ADDR_out,
  input  logic                      ADDR_INC,
  input  logic                      ADDR_DEC,
  input  logic [PAIR_SEL_WIDTH-1:0] ADDR_INC_SEL,
  output logic                      ADDR_WRAP
);

  localparam int NREGS = 1 << SEL_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [NREGS-1:0][DW-1:0] r_regs;
  logic                     r_wrap;

  logic          w_incdec;
  logic [PW-1:0] w_pair_cur;
  logic [PW-1:0] w_pair_nxt;
  logic          w_arith_wrap;
  logic          w_lo_eff;
  logic          w_hi_eff;
  logic          w_addr_hit;

  // Register 0 stays at its reset value when hardwired, so pair 0 already reads {reg1, 0}.
  assign w_incdec     = ADDR_INC ^ ADDR_DEC;
  assign w_pair_cur   = {r_regs[{ADDR_INC_SEL, 1'b1}], r_regs[{ADDR_INC_SEL, 1'b0}]};
  assign w_pair_nxt   = ADDR_INC ? w_pair_cur + PW'(1) : w_pair_cur - PW'(1);
  assign w_arith_wrap = ADDR_INC ? (w_pair_cur == {PW{1'b1}}) : (w_pair_cur == '0);

  // Wrap only counts if at least one half of the pair actually takes the new value.
  assign w_addr_hit = !ADDR_LOAD_bar && (ADDR_LOAD_SEL == ADDR_INC_SEL);
  assign w_lo_eff   = !w_addr_hit
                    && !(!MAIN_LOAD_bar && MAIN_LOAD_SEL == {ADDR_INC_SEL, 1'b0})
                    && !(ZERO_REG && ADDR_INC_SEL == '0);
  assign w_hi_eff   = !w_addr_hit
                    && !(!MAIN_LOAD_bar && MAIN_LOAD_SEL == {ADDR_INC_SEL, 1'b1});

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      r_regs <= '0;
      r_wrap <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (ZERO_REG && i == 0)
          r_regs[i] <= '0;
        else if (!ADDR_LOAD_bar && ADDR_LOAD_SEL == PAIR_SEL_WIDTH'(i / 2))
          r_regs[i] <= (i % 2 == 1) ? ADDR_in[PW-1:DW] : ADDR_in[DW-1:0];
        else if (!MAIN_LOAD_bar && MAIN_LOAD_SEL == SEL_WIDTH'(i))
          r_regs[i] <= MAIN_in;
        else if (w_incdec && ADDR_INC_SEL == PAIR_SEL_WIDTH'(i / 2))
          r_regs[i] <= (i % 2 == 1) ? w_pair_nxt[PW-1:DW] : w_pair_nxt[DW-1:0];
      end
      r_wrap <= w_incdec && (w_lo_eff || w_hi_eff) && w_arith_wrap;
    end
  end

  assign MAIN_out  = MAIN_ASSERT_bar ? '0 : r_regs[MAIN_ASSERT_SEL];
  assign LHS_out   = LHS_ASSERT_bar  ? '0 : r_regs[LHS_ASSERT_SEL];
  assign RHS_out   = RHS_ASSERT_bar  ? '0 : r_regs[RHS_ASSERT_SEL];
  assign ADDR_out  = ADDR_ASSERT_bar ? '0
                   : {r_regs[{ADDR_ASSERT_SEL, 1'b1}], r_regs[{ADDR_ASSERT_SEL, 1'b0}]};
  assign ADDR_WRAP = r_wrap;

endmodule

// File: tb/tb_registerfile_param.sv
// Directed bench for registerfile_param: default 8x8 instance plus a 16-bit, 16-register instance.
module tb_registerfile_param;

  logic        CLK = 1'b0;
  logic        RST_bar;
  logic        MAIN_LOAD_bar, MAIN_ASSERT_bar, LHS_ASSERT_bar, RHS_ASSERT_bar;
  logic [2:0]  MAIN_LOAD_SEL, MAIN_ASSERT_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL;
  logic [7:0]  MAIN_in, MAIN_out, LHS_out, RHS_out;
  logic        ADDR_LOAD_bar, ADDR_ASSERT_bar, ADDR_INC, ADDR_DEC, ADDR_WRAP;
  logic [1:0]  ADDR_LOAD_SEL, ADDR_ASSERT_SEL, ADDR_INC_SEL;
  logic [15:0] ADDR_in, ADDR_out;

  logic        b_ml_bar, b_ma_bar, b_la_bar, b_ra_bar;
  logic [3:0]  b_ml_sel, b_ma_sel, b_la_sel, b_ra_sel;
  logic [15:0] b_main_in, b_main_out, b_lhs_out, b_rhs_out;
  logic        b_al_bar, b_aa_bar, b_inc, b_dec, b_wrap;
  logic [2:0]  b_al_sel, b_aa_sel, b_inc_sel;
  logic [31:0] b_addr_in, b_addr_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  always #5 CLK = ~CLK;

  registerfile_param u_dut (
    .CLK(CLK), .RST_bar(RST_bar),
    .MAIN_LOAD_bar(MAIN_LOAD_bar), .MAIN_LOAD_SEL(MAIN_LOAD_SEL), .MAIN_in(MAIN_in),
    .MAIN_ASSERT_bar(MAIN_ASSERT_bar), .MAIN_ASSERT_SEL(MAIN_ASSERT_SEL), .MAIN_out(MAIN_out),
    .LHS_ASSERT_bar(LHS_ASSERT_bar), .LHS_ASSERT_SEL(LHS_ASSERT_SEL), .LHS_out(LHS_out),
    .RHS_ASSERT_bar(RHS_ASSERT_bar), .RHS_ASSERT_SEL(RHS_ASSERT_SEL), .RHS_out(RHS_out),
    .ADDR_LOAD_bar(ADDR_LOAD_bar), .ADDR_LOAD_SEL(ADDR_LOAD_SEL), .ADDR_in(ADDR_in),
    .ADDR_ASSERT_bar(ADDR_ASSERT_bar), .ADDR_ASSERT_SEL(ADDR_ASSERT_SEL), .ADDR_out(ADDR_out),
    .ADDR_INC(ADDR_INC), .ADDR_DEC(ADDR_DEC), .ADDR_INC_SEL(ADDR_INC_SEL), .ADDR_WRAP(ADDR_WRAP)
  );

  registerfile_param #(.DATA_WIDTH(16), .SEL_WIDTH(4)) u_dut_w (
    .CLK(CLK), .RST_bar(RST_bar),
    .MAIN_LOAD_bar(b_ml_bar), .MAIN_LOAD_SEL(b_ml_sel), .MAIN_in(b_main_in),
    .MAIN_ASSERT_bar(b_ma_bar), .MAIN_ASSERT_SEL(b_ma_sel), .MAIN_out(b_main_out),
    .LHS_ASSERT_bar(b_la_bar), .LHS_ASSERT_SEL(b_la_sel), .LHS_out(b_lhs_out),
    .RHS_ASSERT_bar(b_ra_bar), .RHS_ASSERT_SEL(b_ra_sel), .RHS_out(b_rhs_out),
    .ADDR_LOAD_bar(b_al_bar), .ADDR_LOAD_SEL(b_al_sel), .ADDR_in(b_addr_in),
    .ADDR_ASSERT_bar(b_aa_bar), .ADDR_ASSERT_SEL(b_aa_sel), .ADDR_out(b_addr_out),
    .ADDR_INC(b_inc), .ADDR_DEC(b_dec), .ADDR_INC_SEL(b_inc_sel), .ADDR_WRAP(b_wrap)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drop all write/inc controls; read ports left to the caller.
  task automatic idle();
    MAIN_LOAD_bar = 1'b1; ADDR_LOAD_bar = 1'b1; ADDR_INC = 1'b0; ADDR_DEC = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_bar = 1'b1; idle();
    MAIN_LOAD_SEL = '0; MAIN_in = '0; ADDR_LOAD_SEL = '0; ADDR_in = '0; ADDR_INC_SEL = '0;
    MAIN_ASSERT_bar = 1'b0; LHS_ASSERT_bar = 1'b0; RHS_ASSERT_bar = 1'b0; ADDR_ASSERT_bar = 1'b0;
    MAIN_ASSERT_SEL = '0; LHS_ASSERT_SEL = '0; RHS_ASSERT_SEL = '0; ADDR_ASSERT_SEL = '0;
    b_ml_bar = 1'b1; b_ml_sel = '0; b_main_in = '0; b_ma_bar = 1'b1; b_ma_sel = '0;
    b_la_bar = 1'b1; b_la_sel = '0; b_ra_bar = 1'b1; b_ra_sel = '0;
    b_al_bar = 1'b1; b_al_sel = '0; b_addr_in = '0; b_aa_bar = 1'b0; b_aa_sel = 3'd7;
    b_inc = 1'b0; b_dec = 1'b0; b_inc_sel = '0;
    #1;

    // Preload every register with 0xFF, then wrap pair 3 to arm ADDR_WRAP before reset.
    for (int i = 0; i < 8; i++) begin
      MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'(i); MAIN_in = 8'hFF;
      tick();
    end
    idle();
    b_al_bar = 1'b0; b_al_sel = 3'd7; b_addr_in = 32'hFFFF_FFFF;
    ADDR_INC = 1'b1; ADDR_INC_SEL = 2'd3;
    tick();
    chk("pre_rst_wrap", ADDR_WRAP, 1'b1);
    b_al_bar = 1'b1;
    chk("w_pre_rst", b_addr_out, 32'hFFFF_FFFF);
    RST_bar = 1'b0;
    tick();
    RST_bar = 1'b1; idle();
    chk("rst_wrap", ADDR_WRAP, 1'b0);
    for (int i = 0; i < 8; i++) begin
      MAIN_ASSERT_SEL = 3'(i); LHS_ASSERT_SEL = 3'(i); RHS_ASSERT_SEL = 3'(i);
      #1;
      chk($sformatf("rst_main%0d", i), MAIN_out, 8'h00);
      chk($sformatf("rst_lhs%0d", i), LHS_out, 8'h00);
      chk($sformatf("rst_rhs%0d", i), RHS_out, 8'h00);
    end
    for (int p = 0; p < 4; p++) begin
      ADDR_ASSERT_SEL = 2'(p);
      #1;
      chk($sformatf("rst_addr%0d", p), ADDR_out, 16'h0000);
    end
    chk("w_rst", b_addr_out, 32'h0);

    // Write/read with same-cycle old value.
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd5; MAIN_in = 8'hA5; MAIN_ASSERT_SEL = 3'd5;
    #1;
    chk("same_cycle_old", MAIN_out, 8'h00);
    tick();
    idle();
    LHS_ASSERT_SEL = 3'd5; RHS_ASSERT_SEL = 3'd4;
    #1;
    chk("lhs5", LHS_out, 8'hA5);
    chk("rhs4", RHS_out, 8'h00);
    chk("main5", MAIN_out, 8'hA5);
    MAIN_ASSERT_bar = 1'b1; LHS_ASSERT_bar = 1'b1;
    #1;
    chk("main_off", MAIN_out, 8'h00);
    chk("lhs_off", LHS_out, 8'h00);
    MAIN_ASSERT_bar = 1'b0; LHS_ASSERT_bar = 1'b0;

    // Address load, increment with carry, decrement twice.
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 2'd2; ADDR_in = 16'h12FF; ADDR_ASSERT_SEL = 2'd2;
    tick();
    idle();
    chk("aload2", ADDR_out, 16'h12FF);
    ADDR_INC = 1'b1; ADDR_INC_SEL = 2'd2;
    tick();
    idle();
    chk("inc2", ADDR_out, 16'h1300);
    MAIN_ASSERT_SEL = 3'd5; LHS_ASSERT_SEL = 3'd4;
    #1;
    chk("inc2_r5", MAIN_out, 8'h13);
    chk("inc2_r4", LHS_out, 8'h00);
    chk("inc2_wrap", ADDR_WRAP, 1'b0);
    ADDR_DEC = 1'b1;
    tick();
    chk("dec2a", ADDR_out, 16'h12FF);
    tick();
    idle();
    chk("dec2b", ADDR_out, 16'h12FE);
    ADDR_ASSERT_bar = 1'b1;
    #1;
    chk("addr_off", ADDR_out, 16'h0000);
    ADDR_ASSERT_bar = 1'b0;

    // Wrap pulses.
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 2'd3; ADDR_in = 16'hFFFF; ADDR_ASSERT_SEL = 2'd3;
    tick();
    idle();
    ADDR_INC = 1'b1; ADDR_INC_SEL = 2'd3;
    tick();
    idle();
    chk("wrap_inc_val", ADDR_out, 16'h0000);
    chk("wrap_inc_flag", ADDR_WRAP, 1'b1);
    tick();
    chk("wrap_pulse_end", ADDR_WRAP, 1'b0);
    ADDR_DEC = 1'b1;
    tick();
    idle();
    chk("wrap_dec_val", ADDR_out, 16'hFFFF);
    chk("wrap_dec_flag", ADDR_WRAP, 1'b1);
    ADDR_INC = 1'b1; ADDR_DEC = 1'b1;
    tick();
    idle();
    chk("both_val", ADDR_out, 16'hFFFF);
    chk("both_flag", ADDR_WRAP, 1'b0);
    // Load on the same pair overrides a wrapping inc, so no wrap is reported.
    ADDR_INC = 1'b1; ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 2'd3; ADDR_in = 16'h1234;
    tick();
    idle();
    chk("ovr_val", ADDR_out, 16'h1234);
    chk("ovr_flag", ADDR_WRAP, 1'b0);

    // Per-register priority.
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 2'd1; ADDR_in = 16'hBEEF;
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd3; MAIN_in = 8'h55; ADDR_ASSERT_SEL = 2'd1;
    tick();
    idle();
    chk("prio_load", ADDR_out, 16'hBEEF);
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd3; MAIN_in = 8'h55;
    ADDR_INC = 1'b1; ADDR_INC_SEL = 2'd1;
    tick();
    idle();
    chk("prio_inc", ADDR_out, 16'h55F0);
    chk("prio_flag", ADDR_WRAP, 1'b0);

    // Register 0 behaviour under either build.
    MAIN_LOAD_bar = 1'b0; MAIN_LOAD_SEL = 3'd0; MAIN_in = 8'h77; MAIN_ASSERT_SEL = 3'd0;
    tick();
    idle();
    chk("reg0", MAIN_out, ZERO_REG ? 8'h00 : 8'h77);
    ADDR_LOAD_bar = 1'b0; ADDR_LOAD_SEL = 2'd0; ADDR_in = 16'hABCD; ADDR_ASSERT_SEL = 2'd0;
    tick();
    idle();
    chk("pair0", ADDR_out, ZERO_REG ? 16'hAB00 : 16'hABCD);
    ADDR_DEC = 1'b1; ADDR_INC_SEL = 2'd0;
    tick();
    idle();
    chk("pair0_dec", ADDR_out, ZERO_REG ? 16'hAA00 : 16'hABCC);
    chk("pair0_flag", ADDR_WRAP, 1'b0);

    // Wide instance: carry across 16-bit halves of pair 7.
    b_al_bar = 1'b0; b_al_sel = 3'd7; b_addr_in = 32'h0000_FFFF;
    tick();
    b_al_bar = 1'b1;
    chk("w_load7", b_addr_out, 32'h0000_FFFF);
    b_inc = 1'b1; b_inc_sel = 3'd7;
    tick();
    b_inc = 1'b0;
    chk("w_inc7", b_addr_out, 32'h0001_0000);
    chk("w_flag", b_wrap, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/registerfile_param.md
Name: registerfile_param

Overview:
Parametrised successor of the 8-register CPU register file. Holds 2**SEL_WIDTH general registers of DATA_WIDTH bits; adjacent pairs form 2*DATA_WIDTH-bit address registers. Provides one main-bus read port, LHS/RHS ALU operand read ports, an address-bus read port, a main-bus write port and an address-bus write port. Adds pair decrement and a registered wrap flag, which the previous generation lacks. Sits between the main bus, the ALU operand inputs and the address bus.

Parameters:
DATA_WIDTH, 8, width of each general register and of MAIN/LHS/RHS ports
SEL_WIDTH, 3, register select width; NREGS = 2**SEL_WIDTH, minimum 2
PAIR_SEL_WIDTH, SEL_WIDTH-1 (derived, localparam), pair select width; minimum 1

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_bar  in  1  synchronous active-low reset
MAIN_LOAD_bar  in  1  active-low write of MAIN_in into register MAIN_LOAD_SEL
MAIN_LOAD_SEL  in  SEL_WIDTH  main write select
MAIN_in  in  DATA_WIDTH  main write data
MAIN_ASSERT_bar  in  1  active-low enable for MAIN_out
MAIN_ASSERT_SEL  in  SEL_WIDTH  main read select
MAIN_out  out  DATA_WIDTH  main read data
LHS_ASSERT_bar, RHS_ASSERT_bar  in  1 each  active-low operand read enables
LHS_ASSERT_SEL, RHS_ASSERT_SEL  in  SEL_WIDTH each  operand read selects
LHS_out, RHS_out  out  DATA_WIDTH each  operand read data
ADDR_LOAD_bar  in  1  active-low write of ADDR_in into pair ADDR_LOAD_SEL
ADDR_LOAD_SEL  in  PAIR_SEL_WIDTH  address write pair select
ADDR_in  in  2*DATA_WIDTH  address write data
ADDR_ASSERT_bar  in  1  active-low enable for ADDR_out
ADDR_ASSERT_SEL  in  PAIR_SEL_WIDTH  address read pair select
ADDR_out  out  2*DATA_WIDTH  address read data
ADDR_INC  in  1  active-high increment of pair ADDR_INC_SEL
ADDR_DEC  in  1  active-high decrement of pair ADDR_INC_SEL
ADDR_INC_SEL  in  PAIR_SEL_WIDTH  inc/dec pair select
ADDR_WRAP  out  1  registered: last edge's inc/dec wrapped

Behaviour:
- Pair p = {reg[2p+1] (high), reg[2p] (low)}.
- Reads combinational from current register state. Enabled port shows selected value; disabled port drives all zeros (no tristate).
- Write in cycle N is visible on read ports after the edge ending cycle N; same-cycle read returns the old value.
- Per-register next-state priority at each edge:
  1. RST_bar=0: all registers 0, ADDR_WRAP 0; overrides everything, including mid-sequence inc/dec.
  2. ADDR_LOAD_bar=0 and register is in pair ADDR_LOAD_SEL: corresponding half of ADDR_in.
  3. MAIN_LOAD_bar=0 and MAIN_LOAD_SEL selects register: MAIN_in.
  4. Inc/dec selects register's pair and exactly one of ADDR_INC/ADDR_DEC is high: pair +1 or -1 modulo 2**(2*DATA_WIDTH), carry/borrow across halves.
  5. Otherwise hold.
- ADDR_INC and ADDR_DEC both high: no-op, ADDR_WRAP 0.
- Overlapping writes resolve per register, never per pair. Example: ADDR_LOAD on pair 1 with MAIN_LOAD on reg 2 means reg 2 takes ADDR_in low half. MAIN_LOAD on reg 3 with INC on pair 1 means reg 3 = MAIN_in and reg 2 = low half of the incremented value.
- ADDR_WRAP, set each non-reset edge:
  - 1 iff an inc/dec took effect on at least one register of its pair and the arithmetic wrapped (all-ones +1, or zero -1).
  - Otherwise 0. Single-cycle pulse unless wraps repeat.
- Pure synchronous logic, single clock domain, no latches.

Optional Feature:
Macro REGFILE_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero. Writes to it are ignored; reads return 0.
  - Pair 0 reads as {reg1, 0}. Inc/dec of pair 0 updates reg1 only, as if its low half were 0, and ADDR_WRAP follows that computation.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset: preload all regs 0xFF, RST_bar=0 for one edge -> all MAIN/LHS/RHS reads 0x00, ADDR_out 0x0000, ADDR_WRAP 0.
- Write/read: MAIN_LOAD reg 5 = 0xA5, then LHS sel 5, RHS sel 4, MAIN sel 5 all enabled -> 0xA5, 0x00, 0xA5. Deasserted ports read 0x00. Same-cycle read during write shows old value.
- Address: ADDR_LOAD pair 2 = 0x12FF, then INC pair 2 -> ADDR_out 0x1300, reg 5 = 0x13, reg 4 = 0x00, ADDR_WRAP 0. Then DEC twice -> 0x12FE.
- Wrap: load pair 3 = 0xFFFF, INC -> 0x0000 with ADDR_WRAP 1 for exactly one cycle. DEC -> 0xFFFF with ADDR_WRAP 1. INC and DEC together -> unchanged, ADDR_WRAP 0.
- Priority: ADDR_LOAD pair 1 = 0xBEEF with MAIN_LOAD reg 3 = 0x55 -> pair 1 = 0xBEEF. Then MAIN_LOAD reg 3 = 0x55 with INC pair 1 -> pair 1 = 0x55F0.
- Parametrisation and macro: DATA_WIDTH=16, SEL_WIDTH=4, increment pair 7 from 0x0000FFFF -> 0x00010000. With REGFILE_ZERO_REG_EN, MAIN_LOAD reg 0 = 0x77 -> reg 0 reads 0x00.
